// File: rtl/hazard_forward_ctrl_if.sv
// Bundle of hazard flags into, and pipeline controls out of, hazard_forward_ctrl.
// The master side (decode / comparator logic) drives the equality flags and
// qualifiers; the slave side (the controller) drives mux selects and
// stall/bubble/flush controls.
interface hazard_forward_ctrl_if;
  // Register-compare flags from the forwarding comparators
  logic       id_rs1_eq_ex_rd;
  logic       id_rs1_eq_wb_rd;
  logic       id_rs2_eq_ex_rd;
  logic       id_rs2_eq_wb_rd;
  logic       if_rd_eq_wb_rd;
  // Qualifiers
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_reg_wr;
  logic       wb_reg_wr;
  logic       ex_is_load;
  logic       branch_taken;
  // Controls
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       rf_bypass;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_bubble;
  logic       if_id_flush;

  modport master (
    output id_rs1_eq_ex_rd, id_rs1_eq_wb_rd, id_rs2_eq_ex_rd, id_rs2_eq_wb_rd,
    output if_rd_eq_wb_rd, id_uses_rs1, id_uses_rs2, ex_reg_wr, wb_reg_wr,
    output ex_is_load, branch_taken,
    input  fwd_a_sel, fwd_b_sel, rf_bypass, pc_stall, if_id_stall,
    input  id_ex_bubble, if_id_flush
  );

  modport slave (
    input  id_rs1_eq_ex_rd, id_rs1_eq_wb_rd, id_rs2_eq_ex_rd, id_rs2_eq_wb_rd,
    input  if_rd_eq_wb_rd, id_uses_rs1, id_uses_rs2, ex_reg_wr, wb_reg_wr,
    input  ex_is_load, branch_taken,
    output fwd_a_sel, fwd_b_sel, rf_bypass, pc_stall, if_id_stall,
    output id_ex_bubble, if_id_flush
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: turns raw register-compare flags into registered EX
// operand-mux selects, a register-file write-through bypass select, and the
// PC/IF-ID stall, ID/EX bubble and IF/ID flush controls. Owns the load-use
// stall sequencer (LOAD_LAT total stall cycles per hazard) and branch flush.
// Optional build macro HAZARD_STATS_EN adds saturating 16-bit counters
// stall_cycles (cycles with pc_stall) and flush_count (cycles with if_id_flush).
module hazard_forward_ctrl #(
  parameter int LOAD_LAT = 1,   // total stall cycles per load-use hazard, 1..15
  parameter int CNT_W    = 4    // stall-down counter width, 2**CNT_W > LOAD_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_ctrl_if.slave hf
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]          stall_cycles,
  output logic [15:0]          flush_count
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // A LOAD_LAT of 1 is fully covered by the detection cycle, so the
  // sequencer never leaves RUN in that configuration.
  localparam bit             MULTI_CYCLE = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic             hz1;
  logic             hz2;
  logic             load_use;

  logic             pc_stall_c;
  logic             if_id_stall_c;
  logic             id_ex_bubble_c;
  logic             if_id_flush_c;

  logic [1:0]       fwd_a_d;
  logic [1:0]       fwd_b_d;
  logic             rf_bypass_d;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic             rf_bypass_q;

  // Load-use hazard: the ID instruction needs a value a load in EX has not
  // produced yet, so forwarding cannot help and the pipe must wait.
  assign hz1      = hf.id_uses_rs1 & hf.ex_reg_wr & hf.ex_is_load & hf.id_rs1_eq_ex_rd;
  assign hz2      = hf.id_uses_rs2 & hf.ex_reg_wr & hf.ex_is_load & hf.id_rs2_eq_ex_rd;
  assign load_use = hz1 | hz2;

  // Pipeline controls; a taken branch wins over load-use in RUN because the
  // dependent instruction is being flushed anyway. Held low during reset.
  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    if_id_flush_c  = 1'b0;
    if (!rst) begin
      if (state_q == STALL) begin
        // Only bubbles occupy EX here, so branch_taken is meaningless.
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
      end else if (hf.branch_taken) begin
        if_id_flush_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
      end else if (load_use) begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
      end
    end
  end

  // Next operand selects: EX result beats WB result since it is newer;
  // a bubble entering ID/EX needs no forwarding at all.
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!id_ex_bubble_c) begin
      if (hf.id_uses_rs1 & hf.ex_reg_wr & hf.id_rs1_eq_ex_rd) begin
        fwd_a_d = 2'b01;
      end else if (hf.id_uses_rs1 & hf.wb_reg_wr & hf.id_rs1_eq_wb_rd) begin
        fwd_a_d = 2'b10;
      end
      if (hf.id_uses_rs2 & hf.ex_reg_wr & hf.id_rs2_eq_ex_rd) begin
        fwd_b_d = 2'b01;
      end else if (hf.id_uses_rs2 & hf.wb_reg_wr & hf.id_rs2_eq_wb_rd) begin
        fwd_b_d = 2'b10;
      end
    end
  end

  // Write-through bypass for the IF register read; independent of stalls.
  assign rf_bypass_d = hf.wb_reg_wr & hf.if_rd_eq_wb_rd;

  // Load-use stall sequencer: the detection cycle counts as the first stall
  // cycle, STALL supplies the remaining LOAD_LAT-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (MULTI_CYCLE && load_use && !hf.branch_taken) begin
            state_q <= STALL;
            cnt_q   <= CNT_INIT;
          end
        end
        STALL: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Registered selects that steer the EX operand muxes next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      rf_bypass_q <= 1'b0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      rf_bypass_q <= rf_bypass_d;
    end
  end

  assign hf.fwd_a_sel    = fwd_a_q;
  assign hf.fwd_b_sel    = fwd_b_q;
  assign hf.rf_bypass    = rf_bypass_q;
  assign hf.pc_stall     = pc_stall_c;
  assign hf.if_id_stall  = if_id_stall_c;
  assign hf.id_ex_bubble = id_ex_bubble_c;
  assign hf.if_id_flush  = if_id_flush_c;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Saturating event counters for performance inspection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (pc_stall_c && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      if (if_id_flush_c && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3)
// share one stimulus vector; a cycle-level model derived from the hazard
// rules predicts controls, selects and (optionally) event counters.
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic rs1_ex;
    logic rs1_wb;
    logic rs2_ex;
    logic rs2_wb;
    logic if_wb;
    logic u1;
    logic u2;
    logic exwr;
    logic wbwr;
    logic exld;
    logic br;
  } vin_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  vin_t vin;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl_if hf1 ();
  hazard_forward_ctrl_if hf3 ();

  assign hf1.id_rs1_eq_ex_rd = vin.rs1_ex;
  assign hf1.id_rs1_eq_wb_rd = vin.rs1_wb;
  assign hf1.id_rs2_eq_ex_rd = vin.rs2_ex;
  assign hf1.id_rs2_eq_wb_rd = vin.rs2_wb;
  assign hf1.if_rd_eq_wb_rd  = vin.if_wb;
  assign hf1.id_uses_rs1     = vin.u1;
  assign hf1.id_uses_rs2     = vin.u2;
  assign hf1.ex_reg_wr       = vin.exwr;
  assign hf1.wb_reg_wr       = vin.wbwr;
  assign hf1.ex_is_load      = vin.exld;
  assign hf1.branch_taken    = vin.br;

  assign hf3.id_rs1_eq_ex_rd = vin.rs1_ex;
  assign hf3.id_rs1_eq_wb_rd = vin.rs1_wb;
  assign hf3.id_rs2_eq_ex_rd = vin.rs2_ex;
  assign hf3.id_rs2_eq_wb_rd = vin.rs2_wb;
  assign hf3.if_rd_eq_wb_rd  = vin.if_wb;
  assign hf3.id_uses_rs1     = vin.u1;
  assign hf3.id_uses_rs2     = vin.u2;
  assign hf3.ex_reg_wr       = vin.exwr;
  assign hf3.wb_reg_wr       = vin.wbwr;
  assign hf3.ex_is_load      = vin.exld;
  assign hf3.branch_taken    = vin.br;

`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, fc1, sc3, fc3;
`endif

  hazard_forward_ctrl #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .hf(hf1)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  hazard_forward_ctrl #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .hf(hf3)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc3), .flush_count(fc3)
`endif
  );

  // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush} and {fwd_a, fwd_b, rf_bypass}
  logic [3:0] ctl_obs [2];
  logic [4:0] reg_obs [2];
  assign ctl_obs[0] = {hf1.pc_stall, hf1.if_id_stall, hf1.id_ex_bubble, hf1.if_id_flush};
  assign ctl_obs[1] = {hf3.pc_stall, hf3.if_id_stall, hf3.id_ex_bubble, hf3.if_id_flush};
  assign reg_obs[0] = {hf1.fwd_a_sel, hf1.fwd_b_sel, hf1.rf_bypass};
  assign reg_obs[1] = {hf3.fwd_a_sel, hf3.fwd_b_sel, hf3.rf_bypass};

  // Reference model state
  int         lat      [2] = '{1, 3};
  int         left     [2];   // stall cycles still owed after this one
  logic [1:0] exp_a    [2];
  logic [1:0] exp_b    [2];
  logic       exp_byp  [2];
  int         n_stall  [2];
  int         n_flush  [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic load_use(input vin_t v);
    return (v.u1 & v.exwr & v.exld & v.rs1_ex) | (v.u2 & v.exwr & v.exld & v.rs2_ex);
  endfunction

  function automatic logic [1:0] pick(input logic use_op, input logic ex_eq,
                                      input logic wb_eq, input vin_t v);
    if (use_op && v.exwr && ex_eq) return 2'b01;
    if (use_op && v.wbwr && wb_eq) return 2'b10;
    return 2'b00;
  endfunction

  // One clock: check controls mid-cycle, then selects just after the edge.
  task automatic cycle(input string tag);
    logic       st, bub, fl;
    logic [1:0] na [2];
    logic [1:0] nb [2];
    logic       nby [2];
    int         nleft [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      st = 1'b0; bub = 1'b0; fl = 1'b0;
      nleft[k] = 0;
      if (left[k] > 0) begin
        st = 1'b1; bub = 1'b1;
        nleft[k] = left[k] - 1;
      end else if (vin.br) begin
        fl = 1'b1; bub = 1'b1;
      end else if (load_use(vin)) begin
        st = 1'b1; bub = 1'b1;
        nleft[k] = lat[k] - 1;
      end
      chk($sformatf("%s.ctl.L%0d", tag, lat[k]), 16'(ctl_obs[k]), 16'({st, st, bub, fl}));
      if (bub) begin
        na[k] = 2'b00;
        nb[k] = 2'b00;
      end else begin
        na[k] = pick(vin.u1, vin.rs1_ex, vin.rs1_wb, vin);
        nb[k] = pick(vin.u2, vin.rs2_ex, vin.rs2_wb, vin);
      end
      nby[k] = vin.wbwr & vin.if_wb;
      if (st && n_stall[k] < 65535) n_stall[k]++;
      if (fl && n_flush[k] < 65535) n_flush[k]++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      left[k]    = nleft[k];
      exp_a[k]   = na[k];
      exp_b[k]   = nb[k];
      exp_byp[k] = nby[k];
      chk($sformatf("%s.sel.L%0d", tag, lat[k]), 16'(reg_obs[k]),
          16'({exp_a[k], exp_b[k], exp_byp[k]}));
    end
  endtask

  // Assert reset, confirm everything drops at once, release after an edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.rst_ctl.L%0d", tag, lat[k]), 16'(ctl_obs[k]), 16'h0);
      chk($sformatf("%s.rst_sel.L%0d", tag, lat[k]), 16'(reg_obs[k]), 16'h0);
      left[k] = 0; exp_a[k] = 2'b00; exp_b[k] = 2'b00; exp_byp[k] = 1'b0;
      n_stall[k] = 0; n_flush[k] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vin_t       v;
    logic [10:0] r;
    vin = '0;
    #2;
    do_reset("init");

    // ALU RAW: EX and WB both match rs1, EX must win, no stall
    v = '0; v.exwr = 1; v.wbwr = 1; v.u1 = 1; v.rs1_ex = 1; v.rs1_wb = 1;
    vin = v; cycle("alu_raw");
    chk("alu_raw.fwd_a", 16'(hf1.fwd_a_sel), 16'h1);

    // Load-use on rs2 for one cycle, then quiet
    v = '0; v.exld = 1; v.exwr = 1; v.u2 = 1; v.rs2_ex = 1;
    vin = v; cycle("ld_use");
    vin = '0;
    for (int i = 0; i < 4; i++) cycle($sformatf("ld_tail%0d", i));

    // Branch together with load-use conditions: flush wins
    v = '0; v.br = 1; v.exld = 1; v.exwr = 1; v.u2 = 1; v.rs2_ex = 1; v.u1 = 1; v.rs1_ex = 1;
    vin = v; cycle("br_lu");
    vin = '0; cycle("br_after");

    // WB forward plus register-file bypass, then rs1 unused
    v = '0; v.wbwr = 1; v.rs1_wb = 1; v.u1 = 1; v.if_wb = 1;
    vin = v; cycle("wb_fwd");
    v.u1 = 0;
    vin = v; cycle("wb_nouse");

    // Reset in the second stall cycle of a LOAD_LAT=3 stall
    v = '0; v.exld = 1; v.exwr = 1; v.u1 = 1; v.rs1_ex = 1;
    vin = v; cycle("rst_lu");
    vin = '0;
    do_reset("mid_stall");
    cycle("post_rst0");
    cycle("post_rst1");

    // Randomized traffic, branches kept rare so stalls run to completion
    for (int i = 0; i < 300; i++) begin
      r = 11'($urandom);
      v = r;
      v.br = ($urandom_range(0, 7) == 0);
      vin = v;
      cycle($sformatf("rnd%0d", i));
    end
    vin = '0;
    for (int i = 0; i < 4; i++) cycle($sformatf("drain%0d", i));

`ifdef HAZARD_STATS_EN
    chk("stats.stall.L1", sc1, 16'(n_stall[0]));
    chk("stats.flush.L1", fc1, 16'(n_flush[0]));
    chk("stats.stall.L3", sc3, 16'(n_stall[1]));
    chk("stats.flush.L3", fc3, 16'(n_flush[1]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
